// File: rtl/arith_pkg.sv
// Shared arithmetic-library definitions: divider state encoding and counter sizing.
// The n_bit_mul variants can pull their helpers from here as well.
package arith_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        DIV_IDLE = ST_IDLE,
        DIV_RUN  = ST_RUN,
        DIV_DONE = ST_DONE
    } div_state_e;

    // The iteration counter must be able to hold the value depth itself.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/n_bit_div_step.sv
// One restoring shift-subtract step; chaining BIT_DEPTH copies gives an unrolled divider.
module div_step #(
    parameter int BIT_DEPTH = 32
) (
    input  logic [BIT_DEPTH:0]   rem_i,
    input  logic                 bit_i,
    input  logic [BIT_DEPTH-1:0] div_i,
    output logic [BIT_DEPTH:0]   rem_o,
    output logic                 q_bit_o
);

    logic [BIT_DEPTH+1:0] shifted;

    always_comb begin
        shifted = {rem_i, bit_i};
        q_bit_o = (shifted >= {2'b00, div_i});
        // A successful subtract always leaves a value below the divisor, so BIT_DEPTH+1 bits suffice.
        rem_o   = q_bit_o ? (shifted[BIT_DEPTH:0] - {1'b0, div_i}) : shifted[BIT_DEPTH:0];
    end

endmodule

// File: rtl/n_bit_div.sv
// Sequential restoring divider: one quotient bit per clock, registered results with a done pulse.
// Divide by zero finishes in one cycle with q = all ones, r = a and div_by_zero set.
module n_bit_div
    import arith_pkg::*;
#(
    parameter int BIT_DEPTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [BIT_DEPTH-1:0] a,
    input  logic [BIT_DEPTH-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [BIT_DEPTH-1:0] q,
    output logic [BIT_DEPTH-1:0] r,
    output logic                 div_by_zero
);

    localparam int               CNT_W    = cnt_width(BIT_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_DEPTH - 1);

    div_state_e           state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [BIT_DEPTH-1:0] dvd_q;
    logic [BIT_DEPTH-1:0] dvs_q;
    logic [BIT_DEPTH:0]   rem_q;
    logic [BIT_DEPTH:0]   rem_d;
    logic                 qbit_d;
    logic                 busy_q;
    logic                 done_q;
    logic [BIT_DEPTH-1:0] q_q;
    logic [BIT_DEPTH-1:0] r_q;
    logic                 dbz_q;

    div_step #(
        .BIT_DEPTH(BIT_DEPTH)
    ) u_step (
        .rem_i  (rem_q),
        .bit_i  (dvd_q[BIT_DEPTH-1]),
        .div_i  (dvs_q),
        .rem_o  (rem_d),
        .q_bit_o(qbit_d)
    );

    // dvd_q shifts the dividend out at the top while quotient bits enter at the bottom.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            dbz_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                DIV_IDLE, DIV_DONE: begin
                    if (start) begin
                        dvd_q <= a;
                        dvs_q <= b;
                        rem_q <= '0;
                        cnt_q <= '0;
                        if (b == '0) begin
                            state_q <= DIV_DONE;
                            done_q  <= 1'b1;
                            q_q     <= '1;
                            r_q     <= a;
                            dbz_q   <= 1'b1;
                        end else begin
                            state_q <= DIV_RUN;
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= DIV_IDLE;
                    end
                end
                DIV_RUN: begin
                    rem_q <= rem_d;
                    dvd_q <= {dvd_q[BIT_DEPTH-2:0], qbit_d};
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_q <= DIV_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        q_q     <= {dvd_q[BIT_DEPTH-2:0], qbit_d};
                        r_q     <= rem_d[BIT_DEPTH-1:0];
                        dbz_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= DIV_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign q           = q_q;
    assign r           = r_q;
    assign div_by_zero = dbz_q;

endmodule

// File: doc/n_bit_div.md
# n_bit_div

Sequential unsigned integer divider, the inverse of the team's `n_bit_mul` combinational multiplier. It takes a `BIT_DEPTH`-bit dividend and divisor on a start strobe. It runs a restoring shift-subtract loop that produces one quotient bit per clock, then presents the quotient and remainder with a one-cycle done pulse. It sits beside `n_bit_mul` in the arithmetic library, for datapaths that can trade latency for area.

## Interface
- `BIT_DEPTH`, default 32: operand width. Any integer ≥ 2; need not be a power of two.

- `clk`, input, 1: rising-edge clock; the only clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: request strobe; sampled only while `busy` = 0.
- `a`, input, `BIT_DEPTH`: dividend; sampled on the accepting edge only.
- `b`, input, `BIT_DEPTH`: divisor; sampled on the accepting edge only.
- `busy`, output, 1: high while iterating.
- `done`, output, 1: one-cycle pulse; `q`, `r` and `div_by_zero` are valid.
- `q`, output, `BIT_DEPTH`: quotient.
- `r`, output, `BIT_DEPTH`: remainder.
- `div_by_zero`, output, 1: set with `done` when `b` was 0; held with `q` and `r`.

## Operation
- Reset (async assert, sync release): state IDLE; `busy`, `done`, `q`, `r`, `div_by_zero` = 0; internal registers cleared.
- State machine has three states:
  - IDLE: when `start`=1, latch `a`, `b`. If `b`=0, go to DONE. Otherwise go to RUN with the iteration counter at 0 and the remainder at 0.
  - RUN: on each edge, run one iteration and increment the counter. After the `BIT_DEPTH`-th iteration, go to DONE.
  - DONE: lasts one cycle. `start`=1 here is accepted exactly as in IDLE; otherwise go to IDLE.
- Iteration rule (restoring, MSB first):
  - Remainder register is `BIT_DEPTH`+1 bits wide, to absorb the shift when `b`[MSB]=1.
  - Each step: rem = {rem, next dividend MSB}.
  - If rem ≥ {0,`b`}: subtract the divisor and shift in quotient bit 1. Otherwise shift in quotient bit 0.
- Result rules:
  - Normal: `q` = floor(a/b); `r` = a mod b, always < b.
  - Divide by zero: `q` = all ones, `r` = `a`, `div_by_zero` = 1.
- Output registers load only on the edge entering DONE. They hold until the next result load or reset.
- `div_by_zero` is cleared on the next normal result.
- `start` while `busy`=1 is ignored: operands are not re-sampled and the running division is not disturbed.
- Reset mid-RUN aborts immediately: all outputs return to 0 and no `done` is produced.

## Timing
- `busy` = (state == RUN). It rises the cycle after the accepting edge and stays high exactly `BIT_DEPTH` cycles.
- `done` is high in the cycle after the final iteration edge.
  - Normal latency from accepting edge to `done`-high cycle: `BIT_DEPTH`+1 cycles.
  - Divide by zero: 1 cycle, and `busy` never rises.
- Back-to-back operation: `start` held high in the DONE cycle launches the next division with no idle gap. Throughput is one result per `BIT_DEPTH`+1 cycles.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Shared package `arith_pkg` holds:
  - the state encoding localparams (`ST_IDLE`, `ST_RUN`, `ST_DONE`; 2-bit);
  - the counter-width function (clog2 of `BIT_DEPTH`+1).
  - `n_bit_mul` variants can reuse it.
- Sub-module `div_step` (combinational, parameterised by `BIT_DEPTH`):
  - inputs: partial remainder, incoming dividend bit, divisor;
  - outputs: next remainder and quotient bit.
  - Unrolling it later gives a pipelined divider.
- Top level holds the FSM, counter, operand and shift registers, and output registers.

## Test plan
- `BIT_DEPTH`=8, a=100, b=7, start pulse: `busy` high 8 cycles, `done` on cycle 9, q=14, r=2, `div_by_zero`=0.
- `BIT_DEPTH`=8, a=5, b=0: `done` one cycle after accept, `busy` never high, q=255, r=5, `div_by_zero`=1. Then a=9, b=3: q=3, r=0, `div_by_zero`=0.
- `BIT_DEPTH`=8, boundary operands:
  - a=255, b=1 → q=255, r=0;
  - a=3, b=200 → q=0, r=3;
  - a=255, b=255 → q=1, r=0;
  - a=200, b=129 → q=1, r=71 (exercises the extra remainder bit).
- During RUN of 100/7, pulse `start` with a=1, b=1: ignored, and the result stays q=14, r=2. Then hold `start` high in the DONE cycle with 50/5: `busy` re-rises next cycle, giving q=10, r=0.
- Assert `rst_n`=0 at iteration 4 of 100/7: outputs are 0 immediately and no `done` appears. A new start after release gives a correct result.
- `BIT_DEPTH`=32 random regression (≥10k vectors, including b=0): results are checked against a behavioural `/` and `%` model, and `done` spacing is exactly 33 cycles.
